instr_mem: RTL and testbench
============================

INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 16, number of implemented words, legal range 1..2**ADDR_W.
REQ-004 SHALL have parameter INIT_FILE, default "", binary image loaded at elaboration; empty selects the package default program.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req_i  input  1  fetch request.
REQ-008 SHALL have port addr_i  input  ADDR_W  fetch word address.
REQ-009 SHALL have port ready_o  output  1  fetch accepted this cycle when high with req_i.
REQ-010 SHALL have port stall_i  input  1  consumer cannot take instr_o this cycle.
REQ-011 SHALL have port valid_o  output  1  instr_o holds a fetched word.
REQ-012 SHALL have port instr_o  output  DATA_W  fetched instruction word.
REQ-013 SHALL have port err_o  output  1  the word in instr_o came from an out-of-range address.
REQ-014 SHALL, with LOAD_EN compiled in, add ld_we_i input 1, ld_addr_i input ADDR_W and ld_data_i input DATA_W (program-load write port).

Function
REQ-015 SHALL drive ready_o = !valid_o | !stall_i, combinationally.
REQ-016 SHALL accept a fetch when req_i & ready_o; instr_o, valid_o and err_o update on the next rising edge (latency 1).
REQ-017 SHALL hold instr_o, valid_o and err_o unchanged while valid_o & stall_i.
REQ-018 SHALL clear valid_o on an edge where ready_o is high and req_i is low.
REQ-019 SHALL, for accepted addr_i >= DEPTH, load NOP_WORD into instr_o and set err_o with valid_o; it never outputs X or Z.
REQ-020 SHALL sustain one accepted fetch per cycle with stall_i low (back-to-back, no bubbles).
REQ-021 SHALL, with LOAD_EN, write ld_data_i to ld_addr_i on an edge with ld_we_i high; writes with ld_addr_i >= DEPTH are ignored.
REQ-022 SHALL, on a same-edge write and fetch to the same address, return the old word (read-before-write); the new word is seen from the next fetch.
REQ-023 SHALL leave a held (stalled) instr_o unaffected by writes to its source address.

Reset
REQ-024 SHALL, while rst_n is low, force valid_o=0, err_o=0 and instr_o=NOP_WORD asynchronously.
REQ-025 SHALL not alter memory contents on reset; a fetch accepted on the edge where rst_n goes low is discarded.
REQ-026 SHALL accept fetches from the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with macro INSTR_MEM_LOAD_EN defined, include the load port and writable storage per REQ-014/021/022.
REQ-028 SHALL, without INSTR_MEM_LOAD_EN, omit the load ports and implement read-only storage holding the init image.

Structure
REQ-029 SHALL take NOP_WORD (all zeros), the default DATA_W and the 16-word default program from package instr_mem_pkg.
REQ-030 SHALL place storage and init loading in sub-module instr_mem_array; handshake, range check and output register stay in instr_mem.
REQ-031 SHALL define default program words 0..2 as 0x00410002, 0x00220006, 0x08220002 and words 3..15 as listed in instr_mem_pkg.

Verification
REQ-032 SHALL cover reset: rst_n low mid-stream -> valid_o=0, err_o=0, instr_o=0 immediately; after release fetch addr 0 -> instr_o=0x00410002 one edge later.
REQ-033 SHALL cover streaming: req_i high, addr 0,1,2 on consecutive edges -> 0x00410002, 0x00220006, 0x08220002 on the following consecutive edges.
REQ-034 SHALL cover stall: valid_o high with addr 1 word, stall_i high 3 cycles -> ready_o=0, instr_o stays 0x00220006, new request taken only after stall_i falls.
REQ-035 SHALL cover range: DEPTH=12, fetch addr 13 -> instr_o=0, err_o=1, valid_o=1; next fetch addr 2 -> err_o=0.
REQ-036 SHALL cover load (LOAD_EN): write 0xDEADBEEF to addr 5 with simultaneous fetch of 5 -> old word returned; next fetch of 5 -> 0xDEADBEEF.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory.
//   DEFAULT_DATA_W - default instruction word width
//   NOP_WORD       - word returned for out-of-range fetches and while in reset
//   DEFAULT_PROG   - 16-word program used when no init file is given
package instr_mem_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int PROG_WORDS     = 16;

  localparam logic [DEFAULT_DATA_W-1:0] NOP_WORD = '0;

  localparam logic [DEFAULT_DATA_W-1:0] DEFAULT_PROG [PROG_WORDS] = '{
    32'h0041_0002,  // 0
    32'h0022_0006,  // 1
    32'h0822_0002,  // 2
    32'h0030_8013,  // 3
    32'h00a0_0093,  // 4
    32'h0010_8113,  // 5
    32'h0020_81b3,  // 6
    32'h4031_0233,  // 7
    32'h0041_f2b3,  // 8
    32'h0051_e333,  // 9
    32'h0063_43b3,  // 10
    32'h0073_9413,  // 11
    32'h0083_d493,  // 12
    32'h0094_0533,  // 13
    32'hfea0_0ae3,  // 14
    32'h0000_006f   // 15
  };

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage with elaboration-time image loading.
// Build option: INSTR_MEM_LOAD_EN adds a synchronous write port; without it
// the storage is read-only and holds the init image.
// Ports:
//   clk      - write clock (only with INSTR_MEM_LOAD_EN)
//   wr_en    - write strobe (only with INSTR_MEM_LOAD_EN)
//   wr_addr  - write word address, out-of-range writes are dropped
//   wr_data  - write data
//   rd_addr  - combinational read address (caller range-checks it)
//   rd_data  - word at rd_addr
module instr_mem_array
   import instr_mem_pkg::*;
#(
   parameter int    DATA_W    = DEFAULT_DATA_W,
   parameter int    ADDR_W    = 4,
   parameter int    DEPTH     = 16,
   parameter string INIT_FILE = ""
) (
`ifdef INSTR_MEM_LOAD_EN
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
`endif
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   typedef logic [DEPTH-1:0][DATA_W-1:0] image_t;

   // Package program; words past it default to NOP.
   function automatic image_t init_image();
      image_t img;
      for (int i = 0; i < DEPTH; i++) begin
         if (i < PROG_WORDS) img[i] = DATA_W'(DEFAULT_PROG[i]);
         else                img[i] = DATA_W'(NOP_WORD);
      end
      return img;
   endfunction

   // Contents come from the initializer only; reset never touches storage.
   image_t mem = init_image();

   // Combinational read: a same-edge write lands after the fetch register has
   // already sampled the old word, giving read-before-write.
   assign rd_data = mem[rd_addr];

`ifdef INSTR_MEM_LOAD_EN
   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

   logic wr_in_range;
   assign wr_in_range = ({1'b0, wr_addr} < DEPTH_V);

   always_ff @(posedge clk) begin
      if (wr_en && wr_in_range) mem[wr_addr] <= wr_data;
   end
`endif

endmodule

// File: rtl/instr_mem.sv
// Instruction memory with a one-deep fetch output register and
// ready/valid/stall handshake. Build option macro: INSTR_MEM_LOAD_EN
// (adds the ld_* program-load write port).
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   req_i     - fetch request
//   addr_i    - fetch word address
//   ready_o   - fetch accepted this cycle when high together with req_i
//   stall_i   - consumer cannot take instr_o this cycle
//   valid_o   - instr_o holds a fetched word
//   instr_o   - fetched instruction word
//   err_o     - instr_o came from an out-of-range address
//   ld_we_i   - load write enable   (INSTR_MEM_LOAD_EN)
//   ld_addr_i - load word address   (INSTR_MEM_LOAD_EN)
//   ld_data_i - load data           (INSTR_MEM_LOAD_EN)
module instr_mem
  import instr_mem_pkg::*;
#(
  parameter int    DATA_W    = DEFAULT_DATA_W,
  parameter int    ADDR_W    = 4,
  parameter int    DEPTH     = 16,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              ready_o,
  input  logic              stall_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic              err_o
`ifdef INSTR_MEM_LOAD_EN
  ,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i
`endif
);

  localparam logic [ADDR_W:0]  DEPTH_V = (ADDR_W + 1)'(DEPTH);
  localparam logic [DATA_W-1:0] NOP    = DATA_W'(NOP_WORD);

  logic [DATA_W-1:0] rd_data;
  logic              out_of_range;
  logic              accept;

  instr_mem_array #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
`ifdef INSTR_MEM_LOAD_EN
    .clk     (clk),
    .wr_en   (ld_we_i),
    .wr_addr (ld_addr_i),
    .wr_data (ld_data_i),
`endif
    .rd_addr (addr_i),
    .rd_data (rd_data)
  );

  // The output register can take a new word whenever it is empty or drains.
  assign ready_o      = !valid_o || !stall_i;
  assign accept       = req_i && ready_o;
  assign out_of_range = !({1'b0, addr_i} < DEPTH_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      instr_o <= NOP;
    end else if (accept) begin
      valid_o <= 1'b1;
      err_o   <= out_of_range;
      // Mux away the array read for bad addresses so no X ever escapes.
      instr_o <= out_of_range ? NOP : rd_data;
    end else if (ready_o) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem.sv
module tb_instr_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, stall;
  logic [3:0]  addr;
  logic        ready, valid, err;
  logic [31:0] instr;

  logic        req_r;
  logic [3:0]  addr_r;
  logic        ready_r, valid_r, err_r;
  logic [31:0] instr_r;

`ifdef INSTR_MEM_LOAD_EN
  logic        ld_we;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_we_r;
  logic [3:0]  ld_addr_r;
  logic [31:0] ld_data_r;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_mem #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .INIT_FILE("")) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req),
    .addr_i  (addr),
    .ready_o (ready),
    .stall_i (stall),
    .valid_o (valid),
    .instr_o (instr),
    .err_o   (err)
`ifdef INSTR_MEM_LOAD_EN
    ,
    .ld_we_i   (ld_we),
    .ld_addr_i (ld_addr),
    .ld_data_i (ld_data)
`endif
  );

  instr_mem #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .INIT_FILE("")) dut_r (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req_r),
    .addr_i  (addr_r),
    .ready_o (ready_r),
    .stall_i (stall),
    .valid_o (valid_r),
    .instr_o (instr_r),
    .err_o   (err_r)
`ifdef INSTR_MEM_LOAD_EN
    ,
    .ld_we_i   (ld_we_r),
    .ld_addr_i (ld_addr_r),
    .ld_data_i (ld_data_r)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        req;
    logic [3:0]  addr;
    logic        stall;
    logic        exp_ready;
    logic        exp_valid;
    logic        chk_data;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  initial begin
    //           req addr  stall rdy val chk instr          err
    vecs[0]  = '{1'b1, 4'd0,  1'b0, 1'b1, 1'b1, 1'b1, 32'h0041_0002, 1'b0};
    vecs[1]  = '{1'b1, 4'd1,  1'b0, 1'b1, 1'b1, 1'b1, 32'h0022_0006, 1'b0};
    vecs[2]  = '{1'b1, 4'd2,  1'b0, 1'b1, 1'b1, 1'b1, 32'h0822_0002, 1'b0};
    vecs[3]  = '{1'b1, 4'd15, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_006f, 1'b0};
    vecs[4]  = '{1'b0, 4'd3,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[5]  = '{1'b1, 4'd1,  1'b0, 1'b1, 1'b1, 1'b1, 32'h0022_0006, 1'b0};
    vecs[6]  = '{1'b1, 4'd7,  1'b1, 1'b0, 1'b1, 1'b1, 32'h0022_0006, 1'b0};
    vecs[7]  = '{1'b1, 4'd7,  1'b1, 1'b0, 1'b1, 1'b1, 32'h0022_0006, 1'b0};
    vecs[8]  = '{1'b1, 4'd7,  1'b1, 1'b0, 1'b1, 1'b1, 32'h0022_0006, 1'b0};
    vecs[9]  = '{1'b1, 4'd7,  1'b0, 1'b1, 1'b1, 1'b1, 32'h4031_0233, 1'b0};
    vecs[10] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h4031_0233, 1'b0};
    vecs[11] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[12] = '{1'b1, 4'd4,  1'b1, 1'b1, 1'b1, 1'b1, 32'h00a0_0093, 1'b0};
    vecs[13] = '{1'b1, 4'd5,  1'b0, 1'b1, 1'b1, 1'b1, 32'h0010_8113, 1'b0};

    rst_n = 1'b0; req = 1'b0; addr = '0; stall = 1'b0;
    req_r = 1'b0; addr_r = '0;
`ifdef INSTR_MEM_LOAD_EN
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    ld_we_r = 1'b0; ld_addr_r = '0; ld_data_r = '0;
`endif
    #1;
    check("reset valid", {31'b0, valid}, 32'h0);
    check("reset err",   {31'b0, err},   32'h0);
    check("reset instr", instr,          32'h0);
    check("reset ready", {31'b0, ready}, 32'h1);
    #11 rst_n = 1'b1;  // t=12, between edges

    for (int i = 0; i < 14; i++) begin
      req = vecs[i].req; addr = vecs[i].addr; stall = vecs[i].stall;
      #1;
      check($sformatf("v%0d ready", i), {31'b0, ready}, {31'b0, vecs[i].exp_ready});
      @(posedge clk); #1;
      check($sformatf("v%0d valid", i), {31'b0, valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d instr", i), instr, vecs[i].exp_instr);
        check($sformatf("v%0d err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      end
    end

`ifdef INSTR_MEM_LOAD_EN
    // same-edge write and fetch of addr 5: old word, then new word
    req = 1'b1; addr = 4'd5; stall = 1'b0;
    ld_we = 1'b1; ld_addr = 4'd5; ld_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    ld_we = 1'b0;
    check("rbw old word", instr, 32'h0010_8113);
    @(posedge clk); #1;
    check("rbw new word", instr, 32'hDEAD_BEEF);
    // held word unaffected by a write to its source address
    addr = 4'd6;
    @(posedge clk); #1;
    check("pre-hold word", instr, 32'h0020_81b3);
    stall = 1'b1; ld_we = 1'b1; ld_addr = 4'd6; ld_data = 32'h1234_5678;
    @(posedge clk); #1;
    ld_we = 1'b0;
    @(posedge clk); #1;
    check("held word", instr, 32'h0020_81b3);
    stall = 1'b0;
    @(posedge clk); #1;
    check("after-hold word", instr, 32'h1234_5678);
`endif

    // asynchronous reset asserted mid-cycle with a valid word present
    req = 1'b1; addr = 4'd3; stall = 1'b0;
    @(posedge clk); #1;
    check("pre-reset valid", {31'b0, valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst valid", {31'b0, valid}, 32'h0);
    check("async rst err",   {31'b0, err},   32'h0);
    check("async rst instr", instr,          32'h0);
    @(posedge clk); #1;
    check("held rst valid", {31'b0, valid}, 32'h0);
    #3 rst_n = 1'b1; addr = 4'd0;
    @(posedge clk); #1;
    check("post-rst valid", {31'b0, valid}, 32'h1);
    check("post-rst instr", instr, 32'h0041_0002);
    addr = 4'd5;
    @(posedge clk); #1;
`ifdef INSTR_MEM_LOAD_EN
    check("mem kept over rst", instr, 32'hDEAD_BEEF);
`else
    check("mem kept over rst", instr, 32'h0010_8113);
`endif
    req = 1'b0;

    // range checks on the DEPTH=12 instance
    req_r = 1'b1; addr_r = 4'd11;
    @(posedge clk); #1;
    check("r11 instr", instr_r, 32'h0073_9413);
    check("r11 err", {31'b0, err_r}, 32'h0);
    addr_r = 4'd12;
    @(posedge clk); #1;
    check("r12 instr", instr_r, 32'h0);
    check("r12 err", {31'b0, err_r}, 32'h1);
    addr_r = 4'd13;
    @(posedge clk); #1;
    check("r13 instr", instr_r, 32'h0);
    check("r13 err", {31'b0, err_r}, 32'h1);
    check("r13 valid", {31'b0, valid_r}, 32'h1);
    addr_r = 4'd2;
    @(posedge clk); #1;
    check("r2 instr", instr_r, 32'h0822_0002);
    check("r2 err", {31'b0, err_r}, 32'h0);
    req_r = 1'b0;
    @(posedge clk); #1;
    check("r idle valid", {31'b0, valid_r}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
